// File: rtl/alu.sv
// Registered WIDTH-bit ALU with one-cycle latency: add/sub with carry/borrow, bitwise ops, 1-bit shifts.
// Optional zero/signed-overflow flag outputs z and v are built when ALU_FLAGS_EN is defined.
module alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             c
`ifdef ALU_FLAGS_EN
    ,
    output logic             z,
    output logic             v
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Bit WIDTH of the result carries the carry, borrow or shifted-out bit.
    function automatic logic [WIDTH:0] alu_core(input logic [2:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] w);
        logic [WIDTH:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = {1'b0, x} + {1'b0, w};
            OP_SUB:  r = {1'b0, x} - {1'b0, w};
            OP_AND:  r = {1'b0, x & w};
            OP_OR:   r = {1'b0, x | w};
            OP_XOR:  r = {1'b0, x ^ w};
            OP_NOT:  r = {1'b0, ~x};
            OP_SHL:  r = {x, 1'b0};
            OP_SHR:  r = {x[0], 1'b0, x[WIDTH-1:1]};
            default: r = '0;  // X/Z on the select collapses to zero
        endcase
        return r;
    endfunction

    logic [WIDTH:0]   res_d;
    logic [WIDTH-1:0] y_d, y_q;
    logic             c_d, c_q;

    always_comb begin
        res_d = alu_core(sel, a, b);
        y_d   = res_d[WIDTH-1:0];
        c_d   = res_d[WIDTH];
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
            c_q <= 1'b0;
        end else begin
            y_q <= y_d;
            c_q <= c_d;
        end
    end

    assign y = y_q;
    assign c = c_q;

`ifdef ALU_FLAGS_EN
    logic z_d, z_q;
    logic v_d, v_q;

    always_comb begin
        z_d = (y_d == '0);
        v_d = 1'b0;
        if (sel == OP_ADD)
            v_d = (a[WIDTH-1] == b[WIDTH-1]) && (y_d[WIDTH-1] != a[WIDTH-1]);
        else if (sel == OP_SUB)
            v_d = (a[WIDTH-1] != b[WIDTH-1]) && (y_d[WIDTH-1] != a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    assign z = z_q;
    assign v = v_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the 4-bit alu, plus a random run against an arithmetic reference model.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] y;
    logic       c;
`ifdef ALU_FLAGS_EN
    logic       z;
    logic       v;
`endif

    int total = 0;
    int bad   = 0;

    alu #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (y),
        .c   (c)
`ifdef ALU_FLAGS_EN
        ,
        .z   (z),
        .v   (v)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive between edges, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [2:0] s, input logic [3:0] ia, input logic [3:0] ib);
        @(negedge clk);
        sel = s;
        a   = ia;
        b   = ib;
        @(posedge clk);
        #1;
    endtask

    // Reference model built on plain integer arithmetic.
    function automatic void model(input logic [2:0] s, input int ia, input int ib,
                                  output logic [3:0] ey, output logic ec,
                                  output logic ez, output logic ev);
        int r, sa, sb, sr;
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        ec = 1'b0;
        ev = 1'b0;
        r  = 0;
        case (s)
            3'd0: begin r = ia + ib; ec = (r > 15); sr = sa + sb; ev = (sr > 7) || (sr < -8); end
            3'd1: begin r = ia - ib + 16; ec = (ia < ib); sr = sa - sb; ev = (sr > 7) || (sr < -8); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = 15 - ia;
            3'd6: begin r = ia * 2; ec = (ia >= 8); end
            default: begin r = ia / 2; ec = (ia % 2) == 1; end
        endcase
        ey = 4'(r % 16);
        ez = (ey == 4'd0);
    endfunction

    typedef struct {
        string      tag;
        logic [2:0] s;
        logic [3:0] ia;
        logic [3:0] ib;
        logic [3:0] ey;
        logic       ec;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [3:0] ey;
        logic       ec, ez, ev;

        vecs[0] = '{"add_wrap", 3'b000, 4'd9,     4'd7,     4'd0,     1'b1};
        vecs[1] = '{"sub_brw",  3'b001, 4'd3,     4'd5,     4'd14,    1'b1};
        vecs[2] = '{"sub_eq",   3'b001, 4'd6,     4'd6,     4'd0,     1'b0};
        vecs[3] = '{"and",      3'b010, 4'b1100,  4'b1010,  4'b1000,  1'b0};
        vecs[4] = '{"or",       3'b011, 4'b1100,  4'b1010,  4'b1110,  1'b0};
        vecs[5] = '{"xor",      3'b100, 4'b1100,  4'b1010,  4'b0110,  1'b0};
        vecs[6] = '{"not",      3'b101, 4'b1100,  4'b1010,  4'b0011,  1'b0};
        vecs[7] = '{"shl",      3'b110, 4'b1001,  4'b0000,  4'b0010,  1'b1};
        vecs[8] = '{"shr",      3'b111, 4'b1001,  4'b0000,  4'b0100,  1'b1};

        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        sel = 3'b000;
        #2;
        chk("rst_y", y, 0);
        chk("rst_c", c, 0);
`ifdef ALU_FLAGS_EN
        chk("rst_z", z, 0);
        chk("rst_v", v, 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_y", y, 0);
        chk("rst_hold_c", c, 0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_y", y, 4'hE);
        chk("rel_c", c, 1);

        // Back-to-back directed vectors, each checked one edge after issue.
        foreach (vecs[i]) begin
            apply(vecs[i].s, vecs[i].ia, vecs[i].ib);
            chk({vecs[i].tag, "_y"}, y, vecs[i].ey);
            chk({vecs[i].tag, "_c"}, c, vecs[i].ec);
        end

        // Mid-cycle input changes must not reach the outputs before the edge.
        apply(3'b000, 4'd5, 4'd6);
        chk("lat_y0", y, 4'd11);
        @(negedge clk);
        sel = 3'b011;
        a   = 4'd2;
        b   = 4'd4;
        #2;
        chk("lat_hold_y", y, 4'd11);
        chk("lat_hold_c", c, 0);
        @(posedge clk);
        #1;
        chk("lat_new_y", y, 4'd6);

        // Async reset between edges, released before the next edge.
        apply(3'b000, 4'd15, 4'd1);
        chk("pre_ar_c", c, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_y", y, 0);
        chk("ar_c", c, 0);
        #1;
        rst = 1'b0;
        sel = 3'b100;
        a   = 4'b0101;
        b   = 4'b0011;
        #1;
        chk("ar_rel_y", y, 0);
        @(posedge clk);
        #1;
        chk("ar_load_y", y, 4'b0110);

`ifdef ALU_FLAGS_EN
        apply(3'b000, 4'd7, 4'd1);
        chk("f_add_y", y, 4'd8);
        chk("f_add_v", v, 1);
        chk("f_add_z", z, 0);
        apply(3'b001, 4'd5, 4'd5);
        chk("f_sub0_z", z, 1);
        chk("f_sub0_v", v, 0);
        apply(3'b001, 4'd8, 4'd1);
        chk("f_subv_y", y, 4'd7);
        chk("f_subv_v", v, 1);
`endif

        for (int n = 0; n < 10000; n++) begin
            logic [2:0] rs;
            logic [3:0] ra, rb;
            rs = 3'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            model(rs, int'(ra), int'(rb), ey, ec, ez, ev);
            apply(rs, ra, rb);
            chk("rnd_y", y, ey);
            chk("rnd_c", c, ec);
`ifdef ALU_FLAGS_EN
            chk("rnd_z", z, ez);
            chk("rnd_v", v, ev);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
